uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, word-aligned base of the 16-byte register window.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-003 Parameter DIV_RESET, default 16'd867, bit-period divisor loaded at reset (100 MHz / 115200 baud).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_ce_i  input  1  core data-memory enable.
REQ-007 data_we_i  input  1  core write enable; 1 = write, 0 = read.
REQ-008 data_addr_i  input  32  core data address.
REQ-009 data_i  input  32  core write data.
REQ-010 data_o  output  32  read data, combinational, valid in the same cycle as the access.
REQ-011 sel_o  output  1  combinational; 1 when data_ce_i is high and data_addr_i[31:4] equals BASE_ADDR[31:4].
REQ-012 txd  output  1  serial line, registered, idle high.

Function
REQ-013 Register map at offset data_addr_i[3:0]: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 DIV (R/W), 0xC CTRL (see REQ-033).
REQ-014 Access = sel_o high; write = access with data_we_i high; read = access with data_we_i low.
REQ-015 Write to TXDATA pushes data_i[7:0]; reads of TXDATA return 0.
REQ-016 STATUS read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] FIFO count; all other bits 0.
REQ-017 Write to STATUS with data_i[3]=1 clears overflow; all other STATUS bits are read-only.
REQ-018 DIV holds 16 bits; read returns the value zero-extended; write loads data_i[15:0]; a new value takes effect at the next bit boundary, never mid-bit.
REQ-019 data_o = 0 when sel_o is low, on a write, or at unmapped offsets (bits [1:0] nonzero).
REQ-020 FIFO update order per cycle: pop first, then push; a push is accepted if count < FIFO_DEPTH or a pop occurs in the same cycle.
REQ-021 A rejected push leaves FIFO contents unchanged and sets overflow on the same edge.
REQ-022 FSM states IDLE, START, DATA, STOP; each state step lasts DIV+1 cycles; DIV=0 gives 1 cycle per bit.
REQ-023 IDLE: txd=1; if FIFO not empty, pop the head into the shift register and enter START on that edge.
REQ-024 START drives txd=0; DATA shifts 8 bits LSB first with a 3-bit bit counter; STOP drives txd=1.
REQ-025 At the end of STOP: if FIFO not empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
REQ-026 Latency: TXDATA write captured at edge E; txd falls at edge E+1 if the FSM was IDLE; a frame lasts exactly 10*(DIV+1) cycles.

Reset
REQ-027 On rst high at a clock edge: FIFO emptied, count=0, overflow=0, DIV=DIV_RESET, FSM=IDLE, bit counter and baud counter=0, txd=1.
REQ-028 Reset mid-frame aborts the frame; txd is high from the edge where rst is sampled; no partial byte is resumed.
REQ-029 data_o and sel_o are combinational and follow REQ-011 and REQ-019 during reset; data_o reflects post-reset register values.

Configuration
REQ-030 Macro UART_MMIO_IRQ_EN controls the optional interrupt feature.
REQ-031 With UART_MMIO_IRQ_EN defined: add output irq_o (1 bit) and CTRL register bit0 IE (R/W, reset 0); irq_o is registered and equals IE & empty & ~busy.
REQ-032 With UART_MMIO_IRQ_EN undefined: port irq_o is absent.
REQ-033 CTRL reads 0 and writes to it are ignored when UART_MMIO_IRQ_EN is undefined.

Structure
REQ-034 Package uart_mmio_pkg holds the register offsets, STATUS bit positions, and the FSM state typedef.
REQ-035 Sub-module sync_fifo (parameters WIDTH, DEPTH) holds the FIFO; pointers wrap modulo DEPTH, and a separate count distinguishes full from empty.
REQ-036 The core top level muxes data_o into its load path when sel_o is high.

Verification
REQ-037 DIV=0, write 0x55 to TXDATA: txd from edge E+1 = 0,1,0,1,0,1,0,1,0,1, one cycle each, then stays high; STATUS reads 0x2.
REQ-038 DIV=3, write 0xA5 then 0x3C on consecutive cycles: two frames of 40 cycles each with no idle between them; after the last frame, STATUS empty=1 and busy=0.
REQ-039 DIV=100, 10 writes with FIFO_DEPTH=8: the first byte is popped at once, the next 8 are accepted, the 10th is dropped; STATUS = full=1, overflow=1, count=8; writing 0x8 to STATUS clears overflow.
REQ-040 Assert rst for 1 cycle mid-DATA with DIV=5: txd=1 from the reset edge; STATUS reads 0x2; DIV reads 867.
REQ-041 Reads at BASE_ADDR+0x10, BASE_ADDR+0x6, and with data_ce_i=0: sel_o and data_o as REQ-011/REQ-019 (0x10: sel_o=0, data_o=0; 0x6: sel_o=1, data_o=0; ce=0: sel_o=0, data_o=0).
REQ-042 With UART_MMIO_IRQ_EN defined: write CTRL=1 while idle, so irq_o=1 one edge later; write TXDATA, so irq_o=0 while busy and returns to 1 after the STOP bit.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and the transmit FSM state type.
package uart_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam int ST_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Synchronous FIFO with a separate occupancy count; pop is applied before push,
// so a push into a full FIFO succeeds when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic             w_pop, w_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == L_FULL);
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign o_push_ok = w_push;
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push) r_wr <= r_wr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Optional interrupt output and CTRL.IE are built when UART_MMIO_IRQ_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel_o,
`ifdef UART_MMIO_IRQ_EN
  output logic        irq_o,
`endif
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    w_off;
  logic          w_wr, w_rd, w_push, w_push_ok, w_pop, w_full, w_empty, w_ovf_clr;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_unused;

  logic [15:0]   r_div, r_cur_div, r_baud, w_cur_div_nxt, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_sh, w_sh_nxt;
  logic          r_txd, w_txd_nxt, r_ovf, w_tick;
  tx_state_e     r_state, w_state_nxt;

  assign sel_o     = data_ce_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off     = data_addr_i[3:0];
  assign w_wr      = sel_o && data_we_i;
  assign w_rd      = sel_o && !data_we_i && (w_off[1:0] == 2'b00);
  assign w_push    = w_wr && (w_off == OFF_TXDATA);
  assign w_ovf_clr = w_wr && (w_off == OFF_STATUS) && data_i[ST_OVF];
  assign txd       = r_txd;
  assign w_unused  = &{1'b0, data_i[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (data_i[7:0]),
    .o_data    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_DIV)) r_div <= data_i[15:0];
      // A drop on the same edge as a clear wins so the event is not lost.
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      else if (w_ovf_clr)       r_ovf <= 1'b0;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic r_ie, r_irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_CTRL)) r_ie <= data_i[0];
      r_irq <= r_ie && w_empty && (r_state == S_IDLE);
    end
  end
  assign irq_o = r_irq;
`endif

  always_comb begin
    w_status                       = '0;
    w_status[ST_FULL]              = w_full;
    w_status[ST_EMPTY]             = w_empty;
    w_status[ST_BUSY]              = (r_state != S_IDLE);
    w_status[ST_OVF]               = r_ovf;
    w_status[ST_CNT +: ST_CNT_W]   = ST_CNT_W'(w_count);
  end

  always_comb begin
    data_o = '0;
    if (w_rd) begin
      case (w_off)
        OFF_STATUS: data_o = w_status;
        OFF_DIV:    data_o = {16'h0000, r_div};
`ifdef UART_MMIO_IRQ_EN
        OFF_CTRL:   data_o = {31'h0, r_ie};
`endif
        default:    data_o = '0;
      endcase
    end
  end

  // Transmit FSM. r_cur_div latches DIV at each step start so a DIV write
  // only changes timing from the next bit boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + 16'd1;
    w_cur_div_nxt = r_cur_div;
    w_bit_nxt     = r_bit;
    w_sh_nxt      = r_sh;
    w_pop         = 1'b0;
    w_tick        = (r_baud == r_cur_div);
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_sh_nxt      = w_head;
          w_bit_nxt     = '0;
          w_cur_div_nxt = r_div;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_baud_nxt    = '0;
          w_cur_div_nxt = r_div;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_nxt    = '0;
          w_cur_div_nxt = r_div;
          w_sh_nxt      = {1'b0, r_sh[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_baud_nxt    = '0;
          w_cur_div_nxt = r_div;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_sh_nxt    = w_head;
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_sh_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_cur_div <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_cur_div <= w_cur_div_nxt;
      r_bit     <= w_bit_nxt;
      r_sh      <= w_sh_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio: reset, decode, frame timing,
// back-to-back frames, overflow, mid-frame reset and (if built) the interrupt.
module tb_uart_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] data_o;
  logic        sel_o, txd;
`ifdef UART_MMIO_IRQ_EN
  logic        irq_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (ce),
    .data_we_i   (we),
    .data_addr_i (addr),
    .data_i      (wdata),
    .data_o      (data_o),
    .sel_o       (sel_o),
`ifdef UART_MMIO_IRQ_EN
    .irq_o       (irq_o),
`endif
    .txd         (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1; ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk); ce = 1'b1; we = 1'b0; addr = a;
    #1; d = data_o; s = sel_o; ce = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic s;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    @(negedge clk); rst = 1'b0;
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", d); end
    bus_rd(BASE + 32'h8, d, s);
    n_tests++; if (d !== 32'd867) begin n_fail++; $display("FAIL reset_div: got %0d want 867", d); end
    bus_rd(BASE + 32'h0, d, s);
    n_tests++; if (d !== 32'h0 || s !== 1'b1) begin n_fail++; $display("FAIL txdata_read: got %h sel %b want 0 sel 1", d, s); end
    bus_rd(BASE + 32'hC, d, s);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_read: got %h want 0", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic s;
    bus_rd(BASE + 32'h10, d, s);
    n_tests++; if (s !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL dec_0x10: sel %b data %h want sel 0 data 0", s, d); end
    bus_rd(BASE + 32'h6, d, s);
    n_tests++; if (s !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL dec_0x6: sel %b data %h want sel 1 data 0", s, d); end
    @(negedge clk); ce = 1'b0; we = 1'b0; addr = BASE + 32'h4; #1;
    n_tests++; if (sel_o !== 1'b0 || data_o !== 32'h0) begin n_fail++; $display("FAIL dec_ce0: sel %b data %h want sel 0 data 0", sel_o, data_o); end
    @(negedge clk); ce = 1'b1; we = 1'b1; addr = BASE + 32'h4; wdata = 32'h0; #1;
    n_tests++; if (sel_o !== 1'b1 || data_o !== 32'h0) begin n_fail++; $display("FAIL dec_write: sel %b data %h want sel 1 data 0", sel_o, data_o); end
    @(posedge clk); #1; ce = 1'b0; we = 1'b0;
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL dec_status_after: got %h want 00000002", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d; logic s; logic [7:0] b; logic e;
    b = 8'h55;
    bus_wr(BASE + 32'h8, 32'h0);
    bus_wr(BASE + 32'h0, {24'h0, b});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      n_tests++; if (txd !== e) begin n_fail++; $display("FAIL frame55_bit%0d: got %b want %b", k, txd, e); end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL frame55_idle%0d: got %b want 1", k, txd); end
    end
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL frame55_status: got %h want 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic s; logic [7:0] b; logic e; int j;
    bus_wr(BASE + 32'h8, 32'd3);
    bus_wr(BASE + 32'h0, 32'hA5);
    bus_wr(BASE + 32'h0, 32'h3C);
    for (int k = 0; k < 80; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      b = (k < 40) ? 8'hA5 : 8'h3C;
      j = (k % 40) / 4;
      e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      n_tests++; if (txd !== e) begin n_fail++; $display("FAIL b2b_cyc%0d: got %b want %b", k, txd, e); end
    end
    @(posedge clk); #1;
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", txd); end
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL b2b_status: got %h want 00000002", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic s;
    bus_wr(BASE + 32'h8, 32'd100);
    for (int i = 0; i < 10; i++) bus_wr(BASE + 32'h0, 32'h10 + i);
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h8D) begin n_fail++; $display("FAIL ovf_status: got %h want 0000008d", d); end
    bus_wr(BASE + 32'h4, 32'h7);
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h8D) begin n_fail++; $display("FAIL ovf_ro_bits: got %h want 0000008d", d); end
    bus_wr(BASE + 32'h4, 32'h8);
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h85) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000085", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic s;
    pulse_reset();
    bus_wr(BASE + 32'h8, 32'd5);
    bus_wr(BASE + 32'h0, 32'h00);
    repeat (17) @(posedge clk);
    #1;
    n_tests++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_pre: got %b want 0", txd); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_edge: got %b want 1", txd); end
    @(negedge clk); rst = 1'b0;
    bus_rd(BASE + 32'h4, d, s);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL midrst_status: got %h want 00000002", d); end
    bus_rd(BASE + 32'h8, d, s);
    n_tests++; if (d !== 32'd867) begin n_fail++; $display("FAIL midrst_div: got %0d want 867", d); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_hold%0d: got %b want 1", k, txd); end
    end
  endtask

`ifdef UART_MMIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] d; logic s;
    bus_wr(BASE + 32'h8, 32'd0);
    bus_wr(BASE + 32'hC, 32'h1);
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_pre: got %b want 0", irq_o); end
    @(posedge clk); #1;
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_on: got %b want 1", irq_o); end
    bus_rd(BASE + 32'hC, d, s);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_ctrl_rd: got %h want 1", d); end
    bus_wr(BASE + 32'h0, 32'h5A);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_busy%0d: got %b want 0", k, irq_o); end
    end
    @(posedge clk); #1;
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_done: got %b want 1", irq_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_MMIO_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
